or4_req_resolver: RTL and testbench

- Receiving end of a 4-line OR-merged request bus, the same fan-in the or4 cells merge into one line. Each of A1..A4 is an independent request source.
- Per source: synchronises the line, captures rising edges into a sticky pending bit, and drives the merged indication Z.
- Resolves pending sources one at a time with round-robin priority. Each winner is presented as a one-hot grant under a VALID/ACK handshake.
- Sits beside the or4 cells in the interrupt/wake aggregation path, so a consumer can identify and retire each source.

---
 rtl/or4_req_pkg.sv | 43 ++++
 rtl/or4_req_sync.sv | 26 ++
 rtl/or4_req_resolver.sv | 96 +++++++++
 tb/tb_or4_req_resolver.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or4_req_pkg.sv
// rtl/or4_req_pkg.sv - shared constants, FSM states and grant-pick helpers for the OR4 request resolver
package or4_req_pkg;

    localparam int NCH   = 4;
    localparam int PTR_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // First set pending bit searching upward from ptr, wrapping past the top channel.
    function automatic logic [NCH-1:0] rr_pick(
        input logic [NCH-1:0]   pend,
        input logic [PTR_W-1:0] ptr
    );
        logic [NCH-1:0]   pick;
        logic [PTR_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && pend[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NCH-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (oh[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/or4_req_sync.sv
// rtl/or4_req_sync.sv - multi-flop synchroniser with rising-edge detect on the synchronised level
module or4_req_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/or4_req_resolver.sv
// rtl/or4_req_resolver.sv - captures four async request lines and retires them one grant at a time
module or4_req_resolver
    import or4_req_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RR_EN       = 1'b1
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic           A1,
    input  logic           A2,
    input  logic           A3,
    input  logic           A4,
    output logic           Z,
    output logic           VALID,
    output logic [NCH-1:0] G,
    input  logic           ACK,
    inout  wire            VDD,
    inout  wire            VSS
);

    logic [NCH-1:0]   a_vec;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   pend_q;
    logic [NCH-1:0]   pend_d;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   pick;
    logic [NCH-1:0]   g_q;
    logic [PTR_W-1:0] ptr_q;
    logic             valid_q;
    state_e           state_q;
    wire              unused_supply;

    assign unused_supply = VDD ^ VSS;
    assign a_vec         = {A4, A3, A2, A1};

    for (genvar ch = 0; ch < NCH; ch++) begin : g_sync
        or4_req_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i   (CLK),
            .rst_ni  (RN),
            .async_i (a_vec[ch]),
            .rise_o  (rise[ch])
        );
    end

    // A capture on the channel being retired wins over the clear, so it gets re-offered.
    always_comb begin
        clr = '0;
        if (state_q == OFFER && ACK) begin
            clr = g_q;
        end
        pend_d = (pend_q & ~clr) | rise;
        pick   = rr_pick(pend_q, RR_EN ? ptr_q : '0);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            pend_q  <= '0;
            g_q     <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (|pend_q) begin
                        g_q     <= pick;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (ACK) begin
                        ptr_q   <= oh_to_idx(g_q) + PTR_W'(1);
                        g_q     <= '0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    g_q     <= '0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Z     = |pend_q;
    assign VALID = valid_q;
    assign G     = g_q;

endmodule

// File: tb/tb_or4_req_resolver.sv
// tb/tb_or4_req_resolver.sv - self-checking bench for or4_req_resolver
module tb_or4_req_resolver;

    logic       clk = 1'b0;
    logic       rn;
    logic [3:0] a;
    logic       ack;
    logic       ack_fp;
    logic       z, valid, z_fp, valid_fp;
    logic [3:0] g, g_fp;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e;

    always #5 clk = ~clk;

    or4_req_resolver #(.SYNC_STAGES(2), .RR_EN(1'b1)) dut (
        .CLK(clk), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
        .Z(z), .VALID(valid), .G(g), .ACK(ack), .VDD(vdd), .VSS(vss)
    );

    or4_req_resolver #(.SYNC_STAGES(2), .RR_EN(1'b0)) dut_fp (
        .CLK(clk), .RN(rn), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
        .Z(z_fp), .VALID(valid_fp), .G(g_fp), .ACK(ack_fp), .VDD(vdd), .VSS(vss)
    );

    task automatic do_reset();
        rn = 1'b0; a = 4'h0; ack = 1'b0; ack_fp = 1'b0;
        repeat (2) @(negedge clk);
        rn = 1'b1;
    endtask

    task automatic test_reset();
        rn = 1'b0; a = 4'hF; ack = 1'b0; ack_fp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({z, valid, g} !== 6'b0 || {z_fp, valid_fp, g_fp} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold: got z=%b valid=%b g=%b fp=%b/%b/%b expected all 0",
                         z, valid, g, z_fp, valid_fp, g_fp);
            end
        end
        rn = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (valid !== 1'b0 || z !== 1'b1) begin
            bad++;
            $display("FAIL reset_edge3: got valid=%b z=%b expected valid=0 z=1", valid, z);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || g !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant: got valid=%b g=%b expected 1 0001", valid, g);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        a = 4'b0100;
        repeat (2) @(negedge clk);
        total++;
        if (z !== 1'b0) begin
            bad++;
            $display("FAIL single_z_early: got %b expected 0", z);
        end
        @(negedge clk);
        total++;
        if (z !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL single_edge3: got z=%b valid=%b expected z=1 valid=0", z, valid);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || g !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant: got valid=%b g=%b expected 1 0100", valid, g);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        total++;
        if (z !== 1'b0 || valid !== 1'b0 || g !== 4'b0000) begin
            bad++;
            $display("FAIL single_retire: got z=%b valid=%b g=%b expected 0 0 0000", z, valid, g);
        end
        a = 4'h0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                a = 4'hF;
                exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
                exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
            end else begin
                a = 4'b0011;
                exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
            end
            while (exp_q.size() > 0) begin
                for (int n = 0; n < 20 && valid !== 1'b1; n++) @(negedge clk);
                total++;
                if (valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rr_timeout: got valid=%b expected 1 within 20 cycles", valid);
                    exp_q.delete();
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        bad++;
                        $display("FAIL rr_order: got g=%b expected %b", g, e);
                    end
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                    total++;
                    if (valid !== 1'b0) begin
                        bad++;
                        $display("FAIL rr_idle_gap: got valid=%b expected 0", valid);
                    end
                end
            end
            a = 4'h0;
            repeat (5) @(negedge clk);
        end
        total++;
        if (z !== 1'b0) begin
            bad++;
            $display("FAIL rr_drained: got z=%b expected 0", z);
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        @(negedge clk);
        a = 4'hF;
        for (int n = 0; n < 20 && valid_fp !== 1'b1; n++) @(negedge clk);
        total++;
        if (valid_fp !== 1'b1 || g_fp !== 4'b0001) begin
            bad++;
            $display("FAIL fp_first: got valid=%b g=%b expected 1 0001", valid_fp, g_fp);
        end
        for (int r = 0; r < 3; r++) begin
            a[0] = 1'b0;
            repeat (4) @(negedge clk);
            a[0] = 1'b1;
            repeat (2) @(negedge clk);
            ack_fp = 1'b1;
            @(negedge clk);
            ack_fp = 1'b0;
            total++;
            if (z_fp !== 1'b1 || valid_fp !== 1'b0) begin
                bad++;
                $display("FAIL fp_set_wins: got z=%b valid=%b expected 1 0", z_fp, valid_fp);
            end
            @(negedge clk);
            total++;
            if (valid_fp !== 1'b1 || g_fp !== 4'b0001) begin
                bad++;
                $display("FAIL fp_a1_wins: got valid=%b g=%b expected 1 0001", valid_fp, g_fp);
            end
        end
        ack_fp = 1'b1;
        @(negedge clk);
        ack_fp = 1'b0;
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        while (exp_q.size() > 0) begin
            for (int n = 0; n < 20 && valid_fp !== 1'b1; n++) @(negedge clk);
            total++;
            if (valid_fp !== 1'b1) begin
                bad++;
                $display("FAIL fp_timeout: got valid=%b expected 1", valid_fp);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if (g_fp !== e) begin
                    bad++;
                    $display("FAIL fp_order: got g=%b expected %b", g_fp, e);
                end
                ack_fp = 1'b1;
                @(negedge clk);
                ack_fp = 1'b0;
            end
        end
        a = 4'h0;
    endtask

    task automatic test_set_wins();
        do_reset();
        @(negedge clk);
        a = 4'b0010;
        for (int n = 0; n < 20 && valid !== 1'b1; n++) @(negedge clk);
        total++;
        if (valid !== 1'b1 || g !== 4'b0010) begin
            bad++;
            $display("FAIL sw_offer: got valid=%b g=%b expected 1 0010", valid, g);
        end
        a[1] = 1'b0;
        repeat (4) @(negedge clk);
        a[1] = 1'b1;
        repeat (2) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        total++;
        if (z !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL sw_pend_kept: got z=%b valid=%b expected 1 0", z, valid);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || g !== 4'b0010) begin
            bad++;
            $display("FAIL sw_reoffer: got valid=%b g=%b expected 1 0010", valid, g);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        a = 4'h0;
    endtask

    task automatic test_held_level();
        do_reset();
        @(negedge clk);
        a = 4'b1000;
        exp_q.push_back(4'b1000);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ack = 1'b0;
            if (valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL held_extra_grant: got g=%b expected no grant", g);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        bad++;
                        $display("FAIL held_grant: got g=%b expected %b", g, e);
                    end
                end
                ack = 1'b1;
            end
        end
        @(negedge clk);
        ack = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL held_missing_grant: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (valid !== 1'b0 || z !== 1'b0 || g !== 4'b0000) begin
            bad++;
            $display("FAIL spurious_ack: got valid=%b z=%b g=%b expected 0 0 0000", valid, z, g);
        end
        a = 4'h0;
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        @(negedge clk);
        a = 4'b0010;
        for (int n = 0; n < 20 && valid !== 1'b1; n++) @(negedge clk);
        total++;
        if (valid !== 1'b1 || g !== 4'b0010) begin
            bad++;
            $display("FAIL mid_offer_setup: got valid=%b g=%b expected 1 0010", valid, g);
        end
        #2;
        rn = 1'b0;
        #1;
        total++;
        if (z !== 1'b0 || valid !== 1'b0 || g !== 4'b0000) begin
            bad++;
            $display("FAIL mid_offer_async: got z=%b valid=%b g=%b expected 0 0 0000", z, valid, g);
        end
        @(negedge clk);
        a = 4'h0;
        rn = 1'b1;
    endtask

    initial begin
        rn = 1'b0; a = 4'h0; ack = 1'b0; ack_fp = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fixed_priority();
        test_set_wins();
        test_held_level();
        test_reset_mid_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
